// File: rtl/led_pkg.sv
// Shared types and constants for the LED fade sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package led_pkg;

    // Width of the duty value handed to the PWM generator.
    localparam int DUTY_W = 8;

    // SysClk cycles per PWM period; tied to the 8-bit PWM counter.
    localparam int PWM_PERIOD = 256;
    localparam int PERIOD_W   = $clog2(PWM_PERIOD);

    // Ramp sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } fade_state_e;

    // Command as latched on accept.
    typedef struct packed {
        logic [DUTY_W-1:0] tgt;
        logic [DUTY_W-1:0] step;
        logic              brth;
    } fade_cmd_t;

    // A zero step would stall the ramp forever, so it is promoted to 1.
    function automatic logic [DUTY_W-1:0] norm_step(input logic [DUTY_W-1:0] s);
        return (s == '0) ? DUTY_W'(1) : s;
    endfunction

endpackage

// File: rtl/led_step_timer.sv
// Period counter plus step divider; produces the PWM period pulse and the ramp tick.
// Latency: period_start/tick are combinational from registered counters.
// Backpressure: none; free-running, divider cleared by div_clr.
//
// Ports:
//   clk, rst      - clock and asynchronous active-high reset
//   div_clr       - clears the step divider (command accept)
//   period_start  - high in the last cycle (count 255) of every PWM period
//   tick          - high on the period_start that ends a group of STEP_DIV periods
module led_step_timer
    import led_pkg::*;
#(
    parameter int STEP_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic div_clr,
    output logic period_start,
    output logic tick
);

    // Divider counts 0..STEP_DIV-1, which fits in 8 bits for STEP_DIV <= 256.
    localparam int              DIV_W    = 8;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
    localparam logic [PERIOD_W-1:0] CNT_LAST = PERIOD_W'(PWM_PERIOD - 1);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                div_last;

    assign period_start = (cnt_q == CNT_LAST);
    assign div_last     = (div_q == DIV_LAST);
    assign tick         = period_start && div_last;

    always_comb begin
        // Counter wraps naturally from 255 to 0.
        cnt_d = cnt_q + PERIOD_W'(1);

        div_d = div_q;
        if (div_clr) begin
            // A freshly accepted command always waits a full STEP_DIV
            // periods before its first step, even if this is a tick cycle.
            div_d = '0;
        end else if (period_start) begin
            div_d = div_last ? '0 : div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            div_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/led_fade_ctrl.sv
// Fade/breathe sequencer driving the DutyCycle input of a pwm_led instance.
// Latency: command accepted in one cycle; duty moves only on step ticks, visible from cycle 0 of the next period.
// Backpressure: CmdReady low while a fade is in progress; breathing may be overridden at any time.
//
// Ports:
//   SysClk, Reset                  - clock, asynchronous active-high reset
//   CmdValid/CmdReady              - command handshake
//   CmdTarget, CmdStep, CmdBreathe - target/peak duty, step size (0 -> 1), breathe mode
//   DutyCycle                      - registered duty to the PWM generator
//   PeriodStart                    - pulse in the last cycle of each PWM period
//   Busy                           - registered, high while not IDLE
//   Done                           - one-cycle pulse when a fade reaches its target
module led_fade_ctrl
    import led_pkg::*;
#(
    parameter int STEP_DIV = 4
) (
    input  logic              SysClk,
    input  logic              Reset,
    input  logic              CmdValid,
    output logic              CmdReady,
    input  logic [DUTY_W-1:0] CmdTarget,
    input  logic [DUTY_W-1:0] CmdStep,
    input  logic              CmdBreathe,
    output logic [DUTY_W-1:0] DutyCycle,
    output logic              PeriodStart,
    output logic              Busy,
    output logic              Done
);

    fade_state_e       state_q, state_d;
    fade_cmd_t         cmd_q, cmd_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic              accept;
    logic              tick;
    logic              period_start;

    logic [DUTY_W:0]   up_sum;
    logic [DUTY_W-1:0] floor_val;
    logic [DUTY_W-1:0] down_gap;
    logic              cmd_brth;

    led_step_timer #(
        .STEP_DIV (STEP_DIV)
    ) u_step_timer (
        .clk          (SysClk),
        .rst          (Reset),
        .div_clr      (accept),
        .period_start (period_start),
        .tick         (tick)
    );

    // Breathing can be interrupted; a fade must run to completion.
    assign CmdReady    = (state_q == IDLE) || cmd_q.brth;
    assign accept      = CmdValid && CmdReady;

    assign DutyCycle   = duty_q;
    assign PeriodStart = period_start;
    assign Busy        = busy_q;
    assign Done        = done_q;

    // Breathing to a peak of 0 has nothing to oscillate over; run it as a fade.
    assign cmd_brth    = CmdBreathe && (CmdTarget != '0);

    // 9-bit sum so an overshoot past 255 is caught instead of wrapping.
    assign up_sum      = {1'b0, duty_q} + {1'b0, cmd_q.step};

    // Breathing always swings down to 0; a fade stops at its target.
    assign floor_val   = cmd_q.brth ? '0 : cmd_q.tgt;

    // Duty never sits below the floor while in DOWN, so this cannot underflow.
    assign down_gap    = duty_q - floor_val;

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        duty_d  = duty_q;
        done_d  = 1'b0;

        if (accept) begin
            // Command beats a coincident tick: the step is dropped and the
            // duty holds for this cycle.
            cmd_d.tgt  = CmdTarget;
            cmd_d.step = norm_step(CmdStep);
            cmd_d.brth = cmd_brth;

            if (CmdTarget > duty_q) begin
                state_d = UP;
            end else if (CmdTarget < duty_q) begin
                state_d = DOWN;
            end else if (cmd_brth) begin
                // Already at the peak: start the downward half of the cycle.
                state_d = DOWN;
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end else if (tick) begin
            unique case (state_q)
                UP: begin
                    if (up_sum >= {1'b0, cmd_q.tgt}) begin
                        duty_d = cmd_q.tgt;
                        if (cmd_q.brth) begin
                            state_d = DOWN;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        duty_d = up_sum[DUTY_W-1:0];
                    end
                end
                DOWN: begin
                    if (down_gap <= cmd_q.step) begin
                        duty_d = floor_val;
                        if (cmd_q.brth) begin
                            state_d = UP;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        duty_d = duty_q - cmd_q.step;
                    end
                end
                default: begin
                    // IDLE: nothing to ramp.
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge SysClk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            duty_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            duty_q  <= duty_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_led_fade_ctrl.sv
// Self-checking bench for led_fade_ctrl with a cycle-level behavioural model.
// Latency: n/a.
// Backpressure: commands are held on CmdValid until CmdReady is seen.
module tb_led_fade_ctrl;

    localparam int STEP_DIV = 1;

    logic       SysClk = 1'b0;
    logic       Reset  = 1'b1;
    logic       CmdValid = 1'b0;
    logic       CmdReady;
    logic [7:0] CmdTarget = 8'd0;
    logic [7:0] CmdStep   = 8'd0;
    logic       CmdBreathe = 1'b0;
    logic [7:0] DutyCycle;
    logic       PeriodStart;
    logic       Busy;
    logic       Done;

    int checks = 0;
    int errors = 0;

    led_fade_ctrl #(.STEP_DIV(STEP_DIV)) dut (
        .SysClk      (SysClk),
        .Reset       (Reset),
        .CmdValid    (CmdValid),
        .CmdReady    (CmdReady),
        .CmdTarget   (CmdTarget),
        .CmdStep     (CmdStep),
        .CmdBreathe  (CmdBreathe),
        .DutyCycle   (DutyCycle),
        .PeriodStart (PeriodStart),
        .Busy        (Busy),
        .Done        (Done)
    );

    always #5 SysClk = ~SysClk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 holding, 1 rising towards target, 2 falling towards floor
    int m_cyc, m_duty, m_tgt, m_step, m_mode, m_pcnt, m_done, m_done_cnt;
    bit m_brth;
    int duty_log[$];

    function automatic int m_ready();
        return (m_mode == 0 || m_brth) ? 1 : 0;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_reached();
        if (m_brth) begin
            m_mode = (m_mode == 1) ? 2 : 1;
        end else begin
            m_mode = 0;
            m_done = 1;
        end
    endtask

    task automatic model_edge();
        int  old;
        int  flr;
        bit  ps;
        bit  acc;
        old    = m_duty;
        ps     = ((m_cyc % 256) == 255);
        acc    = CmdValid && (m_ready() == 1);
        m_done = 0;
        if (acc) begin
            m_tgt  = int'(CmdTarget);
            m_step = (CmdStep == 8'd0) ? 1 : int'(CmdStep);
            m_brth = CmdBreathe && (CmdTarget != 8'd0);
            m_pcnt = 0;
            if (m_tgt > m_duty)      m_mode = 1;
            else if (m_tgt < m_duty) m_mode = 2;
            else if (m_brth)         m_mode = 2;
            else begin
                m_mode = 0;
                m_done = 1;
            end
        end else if (ps) begin
            m_pcnt++;
            if (m_mode != 0 && (m_pcnt % STEP_DIV) == 0) begin
                if (m_mode == 1) begin
                    m_duty = imin(m_duty + m_step, m_tgt);
                    if (m_duty == m_tgt) model_reached();
                end else begin
                    flr    = m_brth ? 0 : m_tgt;
                    m_duty = imax(m_duty - m_step, flr);
                    if (m_duty == flr) model_reached();
                end
            end
        end
        m_cyc++;
        if (m_duty != old) duty_log.push_back(m_duty);
        if (m_done != 0) m_done_cnt++;
    endtask

    always @(posedge SysClk or posedge Reset) begin
        if (Reset) begin
            m_cyc = 0; m_duty = 0; m_tgt = 0; m_step = 0; m_mode = 0;
            m_pcnt = 0; m_done = 0; m_brth = 1'b0; m_done_cnt = 0;
        end else begin
            model_edge();
        end
    end

    // Every cycle: DUT outputs against the model.
    always @(negedge SysClk) begin
        chk("duty",   int'(DutyCycle),   m_duty);
        chk("ready",  int'(CmdReady),    m_ready());
        chk("busy",   int'(Busy),        (m_mode != 0) ? 1 : 0);
        chk("done",   int'(Done),        m_done);
        chk("pstart", int'(PeriodStart), ((m_cyc % 256) == 255) ? 1 : 0);
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input int t, input int s, input bit b);
        bit ok;
        @(posedge SysClk); #2;
        CmdTarget  = 8'(t);
        CmdStep    = 8'(s);
        CmdBreathe = b;
        CmdValid   = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge SysClk);
            if (CmdReady) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge SysClk); #2;
        CmdValid = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge SysClk);
            if (Done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("done_timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(posedge SysClk); #2;
        Reset = 1'b1;
        repeat (2) @(posedge SysClk);
        #2 Reset = 1'b0;
    endtask

    task automatic chk_log(input string name, input int exp[$]);
        chk({name, "_len"}, duty_log.size(), exp.size());
        for (int i = 0; i < exp.size() && i < duty_log.size(); i++)
            chk(name, duty_log[i], exp[i]);
    endtask

    // ---------------- directed + random scenarios ----------------
    initial begin
        int e[$];
        int k;
        bit ps_before;
        bit seen;

        // Reset state
        @(negedge SysClk);
        chk("rst_duty",  int'(DutyCycle),   0);
        chk("rst_ready", int'(CmdReady),    1);
        chk("rst_busy",  int'(Busy),        0);
        chk("rst_done",  int'(Done),        0);
        chk("rst_pst",   int'(PeriodStart), 0);
        @(posedge SysClk); #2 Reset = 1'b0;

        // Fade 0 -> 200 step 50
        duty_log.delete();
        send(200, 50, 1'b0);
        @(negedge SysClk);
        chk("fade_ready_low", int'(CmdReady), 0);
        chk("fade_busy_high", int'(Busy), 1);
        wait_done(2000);
        chk("fade_done_busy", int'(Busy), 0);
        chk("fade_done_duty", int'(DutyCycle), 200);
        chk("fade_done_cnt", m_done_cnt, 1);
        e = {50, 100, 150, 200};
        chk_log("fade_seq", e);

        // Overshoot then zero step
        do_reset();
        duty_log.delete();
        send(100, 60, 1'b0);
        wait_done(2000);
        send(103, 0, 1'b0);
        wait_done(2000);
        e = {60, 100, 101, 102, 103};
        chk_log("ovr_seq", e);

        // Fade down, then a no-op fade to the same value
        do_reset();
        send(100, 100, 1'b0);
        wait_done(2000);
        duty_log.delete();
        send(0, 30, 1'b0);
        wait_done(2000);
        e = {70, 40, 10, 0};
        chk_log("down_seq", e);
        send(0, 30, 1'b0);
        @(negedge SysClk);
        chk("same_done", int'(Done), 1);
        chk("same_busy", int'(Busy), 0);
        @(negedge SysClk);
        chk("same_done_once", int'(Done), 0);

        // Breathe, then override with a fade
        do_reset();
        duty_log.delete();
        send(20, 10, 1'b1);
        repeat (7 * 256) @(negedge SysClk);
        e = {10, 20, 10, 0, 10, 20, 10};
        chk_log("brth_seq", e);
        chk("brth_no_done", m_done_cnt, 0);
        send(5, 5, 1'b0);
        wait_done(2000);
        chk("ovrd_duty", int'(DutyCycle), 5);
        chk("ovrd_done_cnt", m_done_cnt, 1);

        // Accept coincident with PeriodStart
        do_reset();
        k = 0;
        while ((m_cyc % 256) != 254 && k < 1000) begin
            @(negedge SysClk);
            k++;
        end
        @(posedge SysClk); #2;
        CmdTarget = 8'd10; CmdStep = 8'd10; CmdBreathe = 1'b0; CmdValid = 1'b1;
        @(negedge SysClk);
        chk("bnd_pstart", int'(PeriodStart), 1);
        chk("bnd_ready",  int'(CmdReady), 1);
        @(posedge SysClk); #2 CmdValid = 1'b0;
        k = 0;
        ps_before = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge SysClk);
            if (DutyCycle != 8'd0) begin
                k = i;
                break;
            end
            ps_before = PeriodStart;
        end
        chk("bnd_latency", k, 257);
        chk("bnd_ps_before", int'(ps_before), 1);
        chk("bnd_done", int'(Done), 1);

        // Reset mid-fade at duty 150
        do_reset();
        send(255, 50, 1'b0);
        k = 0;
        while (DutyCycle != 8'd150 && k < 2000) begin
            @(negedge SysClk);
            k++;
        end
        chk("mid_reach150", int'(DutyCycle), 150);
        #1 Reset = 1'b1;
        #1;
        chk("mid_rst_duty",  int'(DutyCycle), 0);
        chk("mid_rst_busy",  int'(Busy), 0);
        chk("mid_rst_done",  int'(Done), 0);
        chk("mid_rst_ready", int'(CmdReady), 1);
        repeat (3) @(posedge SysClk);
        #2 Reset = 1'b0;
        seen = 1'b0;
        repeat (600) begin
            @(negedge SysClk);
            if (Done) seen = 1'b1;
        end
        chk("mid_no_done", int'(seen), 0);
        chk("mid_ready", int'(CmdReady), 1);

        // Randomised commands; the per-cycle compare does the checking.
        for (int n = 0; n < 10; n++) begin
            int t, s;
            bit b;
            t = $urandom_range(0, 255);
            s = $urandom_range(24, 255);
            b = ($urandom_range(0, 2) == 0);
            send(t, s, b);
            if (b) begin
                repeat ($urandom_range(100, 1500)) @(negedge SysClk);
            end else if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(10, 800)) @(negedge SysClk);
                do_reset();
            end else begin
                // Junk commands while the fade runs must be ignored.
                CmdTarget = 8'($urandom_range(0, 255));
                CmdStep   = 8'($urandom_range(24, 255));
                CmdBreathe = 1'b0;
                CmdValid  = 1'b1;
                if (t != int'(DutyCycle) || Busy) wait_done(4000);
                CmdValid  = 1'b0;
            end
        end
        repeat (20) @(negedge SysClk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
